// File: rtl/opsum_packer_if.sv
// Bundles the reducer-side input handshake and the output-sum buffer write
// channel of the opsum packer. The packer uses the slave view and the
// upstream/buffer side uses the master view.
interface opsum_if #(
  parameter int ROW_NUM = 32,
  parameter int DATA_W  = 16,
  parameter int BUS_W   = 64,
  parameter int ADDR_W  = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      DW_PW_sel;
  logic [ROW_NUM*DATA_W-1:0] reducer2opsum;
  logic [ADDR_W-1:0]         base_addr;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [ADDR_W-1:0]         wr_addr;
  logic [BUS_W-1:0]          wr_data;
  logic [BUS_W/8-1:0]        wr_strb;
  logic                      wr_last;
  logic                      busy;

  modport master (
    output in_valid, DW_PW_sel, reducer2opsum, base_addr, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data, wr_strb, wr_last, busy
  );

  modport slave (
    input  in_valid, DW_PW_sel, reducer2opsum, base_addr, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data, wr_strb, wr_last, busy
  );
endinterface

// File: rtl/opsum_packer.sv
// opsum_packer: captures one reduced partial-sum vector, compacts it for PW
// (all lanes) or DW (every third lane, ten elements) and streams it as
// BUS_W-wide write beats with address, byte strobes and a last flag.
// Every output comes straight from a register.
module opsum_packer #(
  parameter int ROW_NUM = 32,
  parameter int DATA_W  = 16,
  parameter int BUS_W   = 64,
  parameter int ADDR_W  = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  opsum_if.slave   bus
);

  localparam int LPB      = BUS_W / DATA_W;
  localparam int BPL      = DATA_W / 8;
  localparam int NB_PW    = ROW_NUM / LPB;
  localparam int DW_ELEMS = 10;
  localparam int NB_DW    = (DW_ELEMS + LPB - 1) / LPB;
  localparam int BEAT_W   = $clog2(NB_PW) + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ROW_NUM*DATA_W-1:0] r_vec;
  logic                      r_pw;
  logic [ADDR_W-1:0]         r_base;
  logic [BEAT_W-1:0]         r_beat;
  logic [ADDR_W-1:0]         r_wr_addr;
  logic [BUS_W-1:0]          r_wr_data;
  logic [BUS_W/8-1:0]        r_wr_strb;
  logic                      r_wr_last;

  logic                      w_accept;
  logic                      w_step;
  logic [ROW_NUM*DATA_W-1:0] w_src_vec;
  logic                      w_src_pw;
  logic [ADDR_W-1:0]         w_src_base;
  logic [BEAT_W-1:0]         w_src_beat;
  logic [BUS_W-1:0]          w_beat_data;
  logic [BUS_W/8-1:0]        w_beat_strb;
  logic [ADDR_W-1:0]         w_beat_addr;
  logic                      w_beat_last;
  int                        w_elem;

  // Next state, handshake decode and the fields of the beat to present next.
  // On accept the beat is built from the live inputs so beat 0 appears in
  // the very next cycle; afterwards it comes from the latched copy.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = (r_state == IDLE) && bus.in_valid;
    w_step      = (r_state == SEND) && bus.wr_ready;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SEND;
      SEND:    if (w_step && r_wr_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_src_vec  = w_accept ? bus.reducer2opsum : r_vec;
    w_src_pw   = w_accept ? bus.DW_PW_sel     : r_pw;
    w_src_base = w_accept ? bus.base_addr     : r_base;
    w_src_beat = w_accept ? '0 : r_beat + BEAT_W'(1);

    w_beat_data = '0;
    w_beat_strb = '0;
    w_elem      = 0;
    for (int j = 0; j < LPB; j++) begin
      w_elem = int'(w_src_beat) * LPB + j;
      if (w_src_pw) begin
        if (w_elem < ROW_NUM) begin
          w_beat_data[j*DATA_W +: DATA_W] = w_src_vec[w_elem*DATA_W +: DATA_W];
          w_beat_strb[j*BPL +: BPL]       = '1;
        end
      end else if (w_elem < DW_ELEMS) begin
        w_beat_data[j*DATA_W +: DATA_W] = w_src_vec[(3*w_elem)*DATA_W +: DATA_W];
        w_beat_strb[j*BPL +: BPL]       = '1;
      end
    end

    w_beat_addr = w_src_base + ADDR_W'(BUS_W / 8) * ADDR_W'(w_src_beat);
    w_beat_last = w_src_pw ? (w_src_beat == BEAT_W'(NB_PW - 1))
                           : (w_src_beat == BEAT_W'(NB_DW - 1));
  end

  // State, beat counter and registered write-channel outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
      r_wr_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept || (w_step && !r_wr_last)) begin
        r_beat    <= w_src_beat;
        r_wr_addr <= w_beat_addr;
        r_wr_data <= w_beat_data;
        r_wr_strb <= w_beat_strb;
        r_wr_last <= w_beat_last;
      end else if (w_step) begin
        r_wr_last <= 1'b0;
      end
    end
  end

  // Vector, mode and base address are captured only at the input handshake.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_vec  <= bus.reducer2opsum;
      r_pw   <= bus.DW_PW_sel;
      r_base <= bus.base_addr;
    end
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.wr_valid = (r_state == SEND);
  assign bus.busy     = (r_state == SEND);
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.wr_strb  = r_wr_strb;
  assign bus.wr_last  = r_wr_last;

endmodule

// File: tb/tb_opsum_packer.sv
// Self-checking bench for opsum_packer: table of single-beat expectations
// per vector plus hand-written reset, back-pressure and mid-vector reset runs.
`timescale 1ns/1ps
module tb_opsum_packer;
  localparam int ROW_NUM = 32;
  localparam int DATA_W  = 16;
  localparam int BUS_W   = 64;
  localparam int ADDR_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  opsum_if #(.ROW_NUM(ROW_NUM), .DATA_W(DATA_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) bus ();

  opsum_packer #(.ROW_NUM(ROW_NUM), .DATA_W(DATA_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        pw;
    logic [15:0] off;   // lane k carries off + k
    logic [31:0] base;
    int          beat;  // beat to inspect
    logic [63:0] data;
    logic [31:0] addr;
    logic [7:0]  strb;
    logic        last;
    int          nb;
  } vec_t;

  vec_t tbl[8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input logic [15:0] off);
    for (int k = 0; k < ROW_NUM; k++)
      bus.reducer2opsum[k*DATA_W +: DATA_W] = off + 16'(k);
  endtask

  // Present a vector and let it be accepted on the next rising edge.
  task automatic start_vec(input logic pw, input logic [15:0] off, input logic [31:0] base);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready before accept", 64'(bus.in_ready), 64'd1);
    bus.DW_PW_sel = pw;
    bus.base_addr = base;
    set_vec(off);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_row(input int idx, input vec_t r);
    int   cnt;
    logic done;
    cnt  = 0;
    done = 1'b0;
    start_vec(r.pw, r.off, r.base);
    bus.wr_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.wr_valid) begin
        if (cnt == r.beat) begin
          chk($sformatf("row%0d data", idx), bus.wr_data, r.data);
          chk($sformatf("row%0d addr", idx), 64'(bus.wr_addr), 64'(r.addr));
          chk($sformatf("row%0d strb", idx), 64'(bus.wr_strb), 64'(r.strb));
          chk($sformatf("row%0d last", idx), 64'(bus.wr_last), 64'(r.last));
        end
        if (bus.wr_last) done = 1'b1;
        cnt++;
      end
    end
    chk($sformatf("row%0d completed", idx), 64'(done), 64'd1);
    chk($sformatf("row%0d beat count", idx), 64'(cnt), 64'(r.nb));
    @(posedge clk);
    #1;
    chk($sformatf("row%0d in_ready after last", idx), 64'(bus.in_ready), 64'd1);
    chk($sformatf("row%0d busy after last", idx), 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int   cnt;
    int   stall;
    logic done;

    tbl[0] = '{1'b1, 16'h0001, 32'h100, 0, 64'h0004_0003_0002_0001, 32'h100, 8'hFF, 1'b0, 8};
    tbl[1] = '{1'b1, 16'h0001, 32'h100, 3, 64'h0010_000F_000E_000D, 32'h118, 8'hFF, 1'b0, 8};
    tbl[2] = '{1'b1, 16'h0001, 32'h100, 7, 64'h0020_001F_001E_001D, 32'h138, 8'hFF, 1'b1, 8};
    tbl[3] = '{1'b0, 16'h1000, 32'h200, 0, 64'h1009_1006_1003_1000, 32'h200, 8'hFF, 1'b0, 3};
    tbl[4] = '{1'b0, 16'h1000, 32'h200, 1, 64'h1015_1012_100F_100C, 32'h208, 8'hFF, 1'b0, 3};
    tbl[5] = '{1'b0, 16'h1000, 32'h200, 2, 64'h0000_0000_101B_1018, 32'h210, 8'h0F, 1'b1, 3};
    tbl[6] = '{1'b1, 16'h0001, 32'hFFFF_FFF8, 1, 64'h0008_0007_0006_0005, 32'h0, 8'hFF, 1'b0, 8};
    tbl[7] = '{1'b1, 16'h8000, 32'h40, 5, 64'h8017_8016_8015_8014, 32'h68, 8'hFF, 1'b0, 8};

    bus.in_valid      = 1'b0;
    bus.wr_ready      = 1'b0;
    bus.DW_PW_sel     = 1'b1;
    bus.base_addr     = '0;
    bus.reducer2opsum = '0;

    // Reset for two cycles, then release with no input.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    @(negedge clk);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("reset busy",     64'(bus.busy),     64'd0);
    chk("reset wr_last",  64'(bus.wr_last),  64'd0);
    chk("reset wr_data",  bus.wr_data,       64'd0);
    chk("reset wr_addr",  64'(bus.wr_addr),  64'd0);
    chk("reset wr_strb",  64'(bus.wr_strb),  64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_row(i, tbl[i]);

    // Back-pressure on beat 2 with the inputs changing underneath.
    start_vec(1'b1, 16'h0001, 32'h300);
    bus.wr_ready = 1'b1;
    cnt   = 0;
    stall = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.wr_valid) begin
        if (cnt == 2 && stall < 5) begin
          chk("bp beat2 data", bus.wr_data, 64'h000C_000B_000A_0009);
          chk("bp beat2 addr", 64'(bus.wr_addr), 64'h310);
          chk("bp beat2 strb", 64'(bus.wr_strb), 64'hFF);
          chk("bp beat2 last", 64'(bus.wr_last), 64'd0);
          stall++;
          bus.wr_ready  = 1'b0;
          bus.in_valid  = 1'b1;
          bus.DW_PW_sel = 1'b0;
          bus.base_addr = '0;
          set_vec(16'hF000);
        end else begin
          bus.wr_ready = 1'b1;
          bus.in_valid = 1'b0;
          if (cnt == 7) begin
            chk("bp beat7 data", bus.wr_data, 64'h0020_001F_001E_001D);
            chk("bp beat7 addr", 64'(bus.wr_addr), 64'h338);
            chk("bp beat7 last", 64'(bus.wr_last), 64'd1);
          end
          if (bus.wr_last) done = 1'b1;
          cnt++;
        end
      end
    end
    chk("bp completed", 64'(done), 64'd1);
    chk("bp beat count", 64'(cnt), 64'd8);
    @(posedge clk);
    #1;
    chk("bp in_ready after last", 64'(bus.in_ready), 64'd1);

    // Reset while beat 4 of a PW vector is on the bus.
    start_vec(1'b1, 16'h0001, 32'h500);
    bus.wr_ready = 1'b1;
    cnt  = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.wr_valid) begin
        if (cnt == 4) begin
          chk("midrst beat4 addr", 64'(bus.wr_addr), 64'h520);
          rst_n = 1'b0;
          done  = 1'b1;
        end
        cnt++;
      end
    end
    chk("midrst reached beat4", 64'(done), 64'd1);
    @(negedge clk);
    chk("midrst wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst busy",     64'(bus.busy),     64'd0);
    chk("midrst wr_data",  bus.wr_data,       64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 3; i < 6; i++) run_row(10 + i, tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/opsum_packer.md
# opsum_packer

Output-side stage directly downstream of the row reducer. It captures one reduced partial-sum vector, `reducer2opsum`, and compacts it according to the PW/DW mode. It then streams the result as 64-bit write beats, with addresses and byte strobes, into the output-sum buffer through a valid/ready handshake. It decouples the combinational reducer from the buffer write port and absorbs buffer back-pressure.

## Interface
- `ROW_NUM`, 32, number of reducer rows; must be a multiple of 4 and ≥ 30.
- `DATA_W`, 16, width of one partial sum.
- `BUS_W`, 64, write data width; lanes per beat `LPB` = `BUS_W`/`DATA_W` = 4.
- `ADDR_W`, 32, byte address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  reducer vector and controls are valid.
- `in_ready`  out  1  block accepts a vector this cycle.
- `DW_PW_sel`  in  1  1 = PW mode, 0 = DW mode; sampled at input handshake.
- `reducer2opsum`  in  `ROW_NUM`*`DATA_W`  packed reducer output; lane k = bits [k*16 +: 16].
- `base_addr`  in  `ADDR_W`  byte address of the first output word; 8-byte aligned.
- `wr_valid`  out  1  write beat valid.
- `wr_ready`  in  1  buffer accepts the beat.
- `wr_addr`  out  `ADDR_W`  byte address of the beat.
- `wr_data`  out  `BUS_W`  beat data; slot j = bits [j*16 +: 16].
- `wr_strb`  out  `BUS_W`/8  byte enables.
- `wr_last`  out  1  final beat of the vector.
- `busy`  out  1  a vector is held and not fully written.

## Operation
- FSM has two states, IDLE and SEND.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - latch the vector, mode and `base_addr`;
    - set beat counter to 0;
    - go to SEND.
- **Compaction**
  - PW: element e = lane e, for e = 0..`ROW_NUM`-1. `NB` = `ROW_NUM`/4 = 8 beats.
  - DW: element e = lane 3e, for e = 0..9 (only lanes 0,3,…,27 carry sums). `NB` = 3 beats.
  - Lanes 30..31 and non-multiple-of-3 lanes are discarded in DW.
- **Beat b**
  - Slot j carries element 4b+j.
  - Slots with no element are driven 0 and their strobe bytes are 0.
  - `wr_strb`: PW is 0xFF on all beats; DW is 0xFF, 0xFF, 0x0F.
  - `wr_addr` = latched `base_addr` + 8b, wrapping modulo 2^`ADDR_W`.
  - `wr_last`=1 only on beat `NB`-1.
- **SEND**
  - `wr_valid`=1 and `in_ready`=0.
  - On `wr_ready`, increment the beat counter.
  - On the handshake with `wr_last`=1, go to IDLE.
- Data are passed through unmodified; there is no saturation or rounding.
- `busy`=1 exactly when in SEND.

## Timing
- **Reset values** (from `rst_n`=0 sampled on a rising edge):
  - state IDLE;
  - `in_ready`=1, `wr_valid`=0, `wr_last`=0, `busy`=0;
  - `wr_data`=0, `wr_strb`=0, `wr_addr`=0.
- **Reset mid-SEND**
  - Aborts the vector without completing remaining beats.
  - The next cycle shows reset values.
- **Latency**
  - Input handshake in cycle N gives the first beat with `wr_valid`=1 in cycle N+1.
  - Beat b is presented no earlier than N+1+b.
- **Throughput** with `wr_ready` held high:
  - PW: 1 vector per 9 cycles.
  - DW: 1 vector per 4 cycles.
  - `in_ready` rises the cycle after the last-beat handshake; there is no same-cycle overlap.
- **Back-pressure**
  - While `wr_valid`=1 and `wr_ready`=0, hold `wr_data`, `wr_addr`, `wr_strb` and `wr_last` stable.
  - Changes to `reducer2opsum`, `DW_PW_sel` and `base_addr` during SEND have no effect.
- `wr_ready` high while `wr_valid`=0 has no effect.
- `in_valid` high during SEND is ignored; upstream must hold it until `in_ready`.
- All outputs are registered; there is no combinational path from `wr_ready` or `in_valid` to any output.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles, then release with `in_valid`=0 → `in_ready`=1, `wr_valid`=0, `busy`=0, and `wr_data`/`wr_addr`/`wr_strb` all 0.
- **PW streaming:** PW vector with lane k = k+1, `base_addr`=0x100, `wr_ready`=1 → 8 beats.
  - Beat 0 data = 0x0004_0003_0002_0001, addr 0x100.
  - Beat 7 data = 0x0020_001F_001E_001D, addr 0x138, `wr_last`=1.
  - Strobe 0xFF on every beat.
  - `in_ready` high 9 cycles after the accept.
- **DW compaction:** DW vector with lane k = 0x1000+k, `base_addr`=0x200 → 3 beats.
  - Beat 0 = {0x1009, 0x1006, 0x1003, 0x1000}.
  - Beat 2 = {0, 0, 0x101B, 0x1018}, strobe 0x0F, addr 0x210, `wr_last`=1.
- **Back-pressure:** PW vector, `wr_ready` low for 5 cycles on beat 2 → beat 2 fields are stable for all 5 cycles. Changing the input vector meanwhile leaves the streamed data unchanged, and there are still exactly 8 beats.
- **Reset mid-operation:** assert `rst_n`=0 on beat 4 of a PW vector → next cycle `wr_valid`=0 and `in_ready`=1. A following DW vector then emits exactly 3 correct beats.
- **Address wrap:** `base_addr`=0xFFFF_FFF8 in PW mode → beat 1 addr = 0x0000_0000.
